// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: opcodes, FSM states and the bus
// address map used by the sequencer and the units hanging off the core bus.
package bus_sequencer_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_ROM_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      OP_MOV = 2'b00,
      OP_LDI = 2'b01,
      OP_JMP = 2'b10,
      OP_JNZ = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      SQ_FETCH  = 3'd0,
      SQ_DECODE = 3'd1,
      SQ_READ   = 3'd2,
      SQ_WRITE  = 3'd3,
      SQ_HALT   = 3'd4
   } sq_state_t;

   // Read selects live at 0x0n, write selects at 0x8n; 0 is the idle bus.
   localparam logic [7:0] RD_DR0 = 8'h01;
   localparam logic [7:0] RD_DR1 = 8'h02;
   localparam logic [7:0] RD_AR  = 8'h03;
   localparam logic [7:0] RD_RE  = 8'h04;
   localparam logic [7:0] WR_DR0 = 8'h81;
   localparam logic [7:0] WR_DR1 = 8'h82;
   localparam logic [7:0] WR_AR  = 8'h83;
   localparam logic [7:0] WR_ALU = 8'h84;

endpackage

// File: rtl/bus_sequencer_decode.sv
// Combinational instruction splitter: opcode/A/B fields plus the halt and
// jump-taken flags the sequencer FSM needs in its DECODE cycle.
module instr_decode
   import bus_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int INSTR_WIDTH = 2*DATA_WIDTH+2
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [DATA_WIDTH-1:0]  re,
   output logic [1:0]             opcode,
   output logic [DATA_WIDTH-1:0]  fld_a,
   output logic [DATA_WIDTH-1:0]  fld_b,
   output logic                   is_halt,
   output logic                   jump_taken
);

   assign opcode = instr[INSTR_WIDTH-1 -: 2];
   assign fld_a  = instr[2*DATA_WIDTH-1:DATA_WIDTH];
   assign fld_b  = instr[DATA_WIDTH-1:0];

   // JMP with a nonzero B field is the HALT encoding.
   assign is_halt    = (opcode == OP_JMP) && (fld_b != '0);
   assign jump_taken = ((opcode == OP_JMP) && (fld_b == '0)) ||
                       ((opcode == OP_JNZ) && (re != '0));

endmodule

// File: rtl/bus_sequencer.sv
// Instruction fetch / bus transfer sequencer: turns ROM instructions into
// explicit read-then-write transfers on the core bus, with registered outputs.
module bus_sequencer
   import bus_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
   parameter int INSTR_WIDTH    = 2*DATA_WIDTH+2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [INSTR_WIDTH-1:0]    rom_data,
   output logic [DATA_WIDTH-1:0]     addr_bus,
   output logic [DATA_WIDTH-1:0]     data_bus_out,
   input  logic [DATA_WIDTH-1:0]     data_bus_in,
   input  logic [DATA_WIDTH-1:0]     re,
   output logic                      halted
);

   sq_state_t                 state_q, state_d;
   logic [ROM_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]    ir_q, ir_d, cur_instr;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     dout_q, dout_d;
   logic                      halted_q, halted_d;

   logic [1:0]                op_raw;
   opcode_t                   opcode;
   logic [DATA_WIDTH-1:0]     fld_a, fld_b;
   logic                      is_halt, jump_taken;

   // The ROM word is only valid during DECODE; later states work from ir.
   assign cur_instr = (state_q == SQ_DECODE) ? rom_data : ir_q;
   assign opcode    = opcode_t'(op_raw);

   instr_decode #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_decode (
      .instr      (cur_instr),
      .re         (re),
      .opcode     (op_raw),
      .fld_a      (fld_a),
      .fld_b      (fld_b),
      .is_halt    (is_halt),
      .jump_taken (jump_taken)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SQ_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         dout_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         halted_q <= halted_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         SQ_FETCH:  if (run) state_d = SQ_DECODE;
         SQ_DECODE: begin
            case (opcode)
               OP_MOV: state_d = SQ_READ;
               OP_LDI: state_d = SQ_WRITE;
               default: begin
                  if (is_halt) begin
                     state_d = SQ_HALT;
                  end else begin
                     state_d = SQ_FETCH;
                     pc_d    = jump_taken ? fld_a[ROM_ADDR_WIDTH-1:0] : pc_q + 1'b1;
                  end
               end
            endcase
         end
         SQ_READ:   state_d = SQ_WRITE;
         SQ_WRITE: begin
            state_d = SQ_FETCH;
            pc_d    = pc_q + 1'b1;
         end
         SQ_HALT:   state_d = SQ_HALT;
         default:   state_d = SQ_FETCH;
      endcase
   end

   // Output registers are loaded on entry to READ/WRITE so the bus values are
   // present for the whole of that state and return to 0 afterwards.
   always_comb begin
      addr_d   = '0;
      dout_d   = '0;
      halted_d = halted_q;
      wdata_d  = wdata_q;
      ir_d     = ir_q;
      case (state_q)
         SQ_DECODE: begin
            ir_d = rom_data;
            if (state_d == SQ_READ) begin
               addr_d = fld_a;
            end else if (state_d == SQ_WRITE) begin
               addr_d  = fld_b;
               dout_d  = fld_a;
               wdata_d = fld_a;
            end else if (state_d == SQ_HALT) begin
               halted_d = 1'b1;
            end
         end
         SQ_READ: begin
            wdata_d = data_bus_in;
            addr_d  = fld_b;
            dout_d  = data_bus_in;
         end
         default: ;
      endcase
   end

   assign rom_addr     = pc_q;
   assign addr_bus     = addr_q;
   assign data_bus_out = dout_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: an instruction-level model predicts the per-cycle
// bus trace, a compare process checks it, directed cases pin known values.
module tb_bus_sequencer;
   import bus_sequencer_pkg::*;

   localparam int DW    = 8;
   localparam int RAW   = 5;
   localparam int IW    = 2*DW+2;
   localparam int ROM_N = 1 << RAW;
   localparam int MAXC  = 200;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           run = 1'b0;
   logic [RAW-1:0] rom_addr;
   logic [IW-1:0]  rom_data = '0;
   logic [DW-1:0]  addr_bus, dbus_wr, dbus_rd;
   logic [DW-1:0]  re = '0;
   logic           halted;

   always #5 clk = ~clk;

   bus_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .addr_bus     (addr_bus),
      .data_bus_out (dbus_wr),
      .data_bus_in  (dbus_rd),
      .re           (re),
      .halted       (halted)
   );

   // Program ROM (synchronous) and a four-unit stand-in for the core.
   logic [IW-1:0] rom [ROM_N];
   logic [DW-1:0] units [4];
   logic [DW-1:0] units_init [4];
   logic [DW-1:0] rd_list [4] = '{RD_DR0, RD_DR1, RD_AR, RD_RE};
   logic [DW-1:0] wr_list [4] = '{WR_DR0, WR_DR1, WR_AR, WR_ALU};

   always @(posedge clk) rom_data <= rom[rom_addr];
   assign dbus_rd = (addr_bus != '0 && !addr_bus[7]) ? units[addr_bus[1:0]] : '0;
   always @(posedge clk) if (addr_bus[7]) units[addr_bus[1:0]] = dbus_wr;

   // Stimulus per cycle and the model's expected trace.
   bit             run_at [MAXC];
   logic [DW-1:0]  re_at  [MAXC];
   logic [RAW-1:0] exp_rom [MAXC];
   logic [DW-1:0]  exp_addr [MAXC];
   logic [DW-1:0]  exp_data [MAXC];
   logic           exp_halt [MAXC];
   logic [RAW-1:0] act_rom [MAXC];
   logic [DW-1:0]  act_addr [MAXC];
   logic [DW-1:0]  act_data [MAXC];
   logic           act_halt [MAXC];

   int checks = 0;
   int errors = 0;
   int cmp_cyc = 0;
   int seg_len = 0;
   bit active = 1'b0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [IW-1:0] mk(input opcode_t op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      return {op, a, b};
   endfunction

   task automatic put(input int c, input logic [RAW-1:0] pc, input logic [DW-1:0] a,
                      input logic [DW-1:0] d, input logic h);
      if (c < MAXC) begin
         exp_rom[c]  = pc;
         exp_addr[c] = a;
         exp_data[c] = d;
         exp_halt[c] = h;
      end
   endtask

   // Instruction-level interpreter: walks the program and emits the bus
   // activity each instruction must produce, cycle by cycle.
   task automatic build_expect(input int n);
      logic [DW-1:0]  u [4];
      logic [RAW-1:0] pc;
      logic [IW-1:0]  w;
      logic [1:0]     op;
      logic [DW-1:0]  a, b, v;
      bit             halt;
      int             c;
      for (int i = 0; i < 4; i++) u[i] = units_init[i];
      pc = '0;
      c = 0;
      halt = 1'b0;
      while (c < n) begin
         if (halt) begin
            put(c, pc, 8'h00, 8'h00, 1'b1);
            c++;
         end else begin
            put(c, pc, 8'h00, 8'h00, 1'b0);
            if (!run_at[c]) begin
               c++;
            end else begin
               c++;
               put(c, pc, 8'h00, 8'h00, 1'b0);
               w  = rom[pc];
               op = w[IW-1 -: 2];
               a  = w[2*DW-1:DW];
               b  = w[DW-1:0];
               if (op == OP_MOV) begin
                  v = (a != 0 && !a[7]) ? u[a[1:0]] : 8'h00;
                  put(c + 1, pc, a, 8'h00, 1'b0);
                  put(c + 2, pc, b, v, 1'b0);
                  if (b[7]) u[b[1:0]] = v;
                  pc = pc + 1'b1;
                  c += 2;
               end else if (op == OP_LDI) begin
                  put(c + 1, pc, b, a, 1'b0);
                  if (b[7]) u[b[1:0]] = a;
                  pc = pc + 1'b1;
                  c += 1;
               end else if (op == OP_JMP) begin
                  if (b != 0) halt = 1'b1;
                  else pc = a[RAW-1:0];
               end else begin
                  pc = (c < MAXC && re_at[c] != 0) ? a[RAW-1:0] : pc + 1'b1;
               end
               c++;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (active && cmp_cyc < seg_len) begin
         check($sformatf("rom_addr@%0d", cmp_cyc), 32'(rom_addr), 32'(exp_rom[cmp_cyc]));
         check($sformatf("addr_bus@%0d", cmp_cyc), 32'(addr_bus), 32'(exp_addr[cmp_cyc]));
         check($sformatf("data_bus_out@%0d", cmp_cyc), 32'(dbus_wr), 32'(exp_data[cmp_cyc]));
         check($sformatf("halted@%0d", cmp_cyc), 32'(halted), 32'(exp_halt[cmp_cyc]));
         cmp_cyc++;
      end
   end

   task automatic capture(input int c);
      act_rom[c]  = rom_addr;
      act_addr[c] = addr_bus;
      act_data[c] = dbus_wr;
      act_halt[c] = halted;
   endtask

   // Reset, release, then run n cycles; abort_at >= 0 pulls reset mid-cycle.
   task automatic run_segment(input int n, input int abort_at);
      active = 1'b0;
      rst_n  = 1'b0;
      for (int i = 0; i < 4; i++) units[i] = units_init[i];
      run = run_at[0];
      re  = re_at[0];
      repeat (2) @(posedge clk);
      #1;
      seg_len = n;
      cmp_cyc = 0;
      rst_n   = 1'b1;
      active  = 1'b1;
      capture(0);
      for (int c = 1; c < n; c++) begin
         @(posedge clk);
         #1;
         run = run_at[c];
         re  = re_at[c];
         capture(c);
         if (c == abort_at) begin
            #2;
            active = 1'b0;
            rst_n  = 1'b0;
            #1;
            check("abort_addr_bus", 32'(addr_bus), 32'h0);
            check("abort_data_bus_out", 32'(dbus_wr), 32'h0);
            check("abort_rom_addr", 32'(rom_addr), 32'h0);
            repeat (3) @(posedge clk);
            #1;
            check("abort_no_write", 32'(units[WR_AR[1:0]]), 32'(units_init[WR_AR[1:0]]));
            return;
         end
      end
      @(posedge clk);
      #1;
      active = 1'b0;
   endtask

   task automatic stim_default();
      for (int i = 0; i < ROM_N; i++) rom[i] = mk(OP_JMP, 8'h00, 8'h00);
      for (int c = 0; c < MAXC; c++) begin
         run_at[c] = 1'b1;
         re_at[c]  = 8'h00;
      end
      units_init[0] = 8'h11;
      units_init[1] = 8'h3C;
      units_init[2] = 8'h55;
      units_init[3] = 8'h44;
   endtask

   task automatic stim_random();
      for (int i = 0; i < ROM_N; i++) begin
         case ($urandom_range(0, 3))
            0: rom[i] = mk(OP_MOV, rd_list[$urandom_range(0, 3)], wr_list[$urandom_range(0, 3)]);
            1: rom[i] = mk(OP_LDI, 8'($urandom), wr_list[$urandom_range(0, 3)]);
            2: rom[i] = mk(OP_JMP, 8'($urandom),
                           ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            default: rom[i] = mk(OP_JNZ, 8'($urandom), 8'($urandom));
         endcase
      end
      for (int c = 0; c < MAXC; c++) begin
         run_at[c] = ($urandom_range(0, 9) != 0);
         re_at[c]  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      for (int i = 0; i < 4; i++) units_init[i] = 8'($urandom);
   endtask

   initial begin
      logic [DW-1:0] acc;

      // LDI 0x5A -> wr_dr0
      stim_default();
      rom[0] = mk(OP_LDI, 8'h5A, WR_DR0);
      build_expect(12);
      run_segment(12, -1);
      check("reset_rom_addr", 32'(act_rom[0]), 32'h0);
      check("reset_addr_bus", 32'(act_addr[0]), 32'h0);
      check("reset_halted", 32'(act_halt[0]), 32'h0);
      check("ldi_decode_idle", 32'(act_addr[1]), 32'h0);
      check("ldi_addr", 32'(act_addr[2]), 32'(WR_DR0));
      check("ldi_data", 32'(act_data[2]), 32'h5A);
      check("ldi_pc", 32'(act_rom[3]), 32'h1);

      // MOV rd_dr0 -> wr_ar, run dropped during READ
      stim_default();
      rom[0] = mk(OP_MOV, RD_DR0, WR_AR);
      for (int c = 2; c < MAXC; c++) run_at[c] = 1'b0;
      build_expect(14);
      run_segment(14, -1);
      check("mov_read_addr", 32'(act_addr[2]), 32'(RD_DR0));
      check("mov_read_data", 32'(act_data[2]), 32'h0);
      check("mov_write_addr", 32'(act_addr[3]), 32'(WR_AR));
      check("mov_write_data", 32'(act_data[3]), 32'h3C);
      check("stall_rom_addr", 32'(act_rom[13]), 32'h1);
      check("stall_addr_bus", 32'(act_addr[13]), 32'h0);

      // JNZ 0x10, re = 0 then re = 1
      stim_default();
      rom[0] = mk(OP_JNZ, 8'h10, 8'h00);
      build_expect(8);
      run_segment(8, -1);
      check("jnz_not_taken", 32'(act_rom[2]), 32'h1);
      re_at[1] = 8'h01;
      build_expect(8);
      run_segment(8, -1);
      check("jnz_taken", 32'(act_rom[2]), 32'h10);

      // pc wrap: jump to all-ones, execute LDI there
      stim_default();
      rom[0] = mk(OP_JMP, 8'h1F, 8'h00);
      rom[ROM_N-1] = mk(OP_LDI, 8'h77, WR_DR1);
      build_expect(12);
      run_segment(12, -1);
      check("wrap_target", 32'(act_rom[2]), 32'h1F);
      check("wrap_zero", 32'(act_rom[5]), 32'h0);

      // HALT, then 20+ idle cycles
      stim_default();
      rom[0] = mk(OP_JMP, 8'h00, 8'h01);
      build_expect(25);
      run_segment(25, -1);
      check("halt_before", 32'(act_halt[1]), 32'h0);
      check("halt_after", 32'(act_halt[2]), 32'h1);
      acc = '0;
      for (int c = 2; c < 25; c++) acc |= act_addr[c];
      check("halt_bus_idle", 32'(acc), 32'h0);

      // run held low after reset
      stim_default();
      for (int c = 0; c < MAXC; c++) run_at[c] = 1'b0;
      build_expect(30);
      run_segment(30, -1);
      acc = '0;
      for (int c = 0; c < 30; c++) acc |= act_addr[c];
      check("norun_rom_addr", 32'(act_rom[29]), 32'h0);
      check("norun_bus_idle", 32'(acc), 32'h0);

      // reset during WRITE of a MOV, then restart at ROM[0]
      stim_default();
      rom[0] = mk(OP_MOV, RD_DR0, WR_AR);
      build_expect(12);
      run_segment(12, 3);
      check("abort_pre_write", 32'(act_addr[3]), 32'(WR_AR));
      build_expect(12);
      run_segment(12, -1);
      check("restart_read", 32'(act_addr[2]), 32'(RD_DR0));

      // randomized programs
      for (int s = 0; s < 8; s++) begin
         stim_random();
         build_expect(150);
         run_segment(150, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
